dma_mover: RTL
==============

DMA_MOVER -- requirements
Module: dma_mover

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the address and length width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the NASTI data width; the byte count per beat is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_BURST, default 8, the maximum beats per burst.
REQ-004 aclk  in  1  clock.
REQ-005 aresetn  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  start request; sampled only in IDLE.
REQ-007 from_addr, to_addr, length  in  ADDR_WIDTH  source address, destination address, byte count.
REQ-008 done  out  1  high = idle/finished; low = transfer in progress.
REQ-009 error  out  1  sticky error flag for the last transfer.
REQ-010 ar_addr/ar_len(8)/ar_size(3)/ar_burst(2)/ar_valid out; ar_ready in.
REQ-011 r_data(DATA_WIDTH)/r_resp(2)/r_last/r_valid in; r_ready out.
REQ-012 aw_addr/aw_len(8)/aw_size(3)/aw_burst(2)/aw_valid out; aw_ready in.
REQ-013 w_data(DATA_WIDTH)/w_strb(DATA_WIDTH/8)/w_last/w_valid out; w_ready in.
REQ-014 b_resp(2)/b_valid in; b_ready out.

Function
REQ-015 SHALL implement the states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP; read and write phases never overlap.
REQ-016 IDLE with en=1: latch the addresses and beats=length>>log2(DATA_WIDTH/8), clear error, drive done=0 on the next cycle, and go to RD_ADDR; if beats=0, go back to IDLE instead (done low for exactly 1 cycle, no bus traffic).
REQ-017 Burst beats: n = min(remaining, MAX_BURST, beats to the next 4KB boundary of the source, beats to the next 4KB boundary of the destination); ar_len=aw_len=n-1.
REQ-018 The low address bits below the beat size SHALL be ignored (addresses treated as aligned); ar_size=aw_size=log2(DATA_WIDTH/8); ar_burst=aw_burst=INCR.
REQ-019 Valid signals SHALL follow the standard handshake: once asserted, valid and its payload stay stable until ready; a transfer occurs on the cycle where valid and ready are both high.
REQ-020 RD_ADDR: ar_valid=1 until the handshake, then RD_DATA.
REQ-021 RD_DATA: r_ready=1; each accepted beat is pushed into the buffer; the beat with r_last (or the nth beat) moves to WR_ADDR.
REQ-022 Excess beats beyond n SHALL be ignored.
REQ-023 WR_ADDR: aw_valid=1 until the handshake, then WR_DATA.
REQ-024 WR_DATA: w_valid=1 while the buffer is non-empty; w_strb all ones; w_last on beat n; a handshake on the last beat moves to WR_RESP.
REQ-025 WR_RESP: b_ready=1; on b_valid, advance the source and destination by n beats and reduce remaining by n; go to RD_ADDR if remaining>0, else IDLE with done=1.
REQ-026 Any r_resp≠OKAY: set error, drain the rest of the burst, skip the write phase, then IDLE.
REQ-027 b_resp≠OKAY: set error, then IDLE.
REQ-028 error SHALL stay valid while done=1 and clear only on the next accepted en.
REQ-029 en while not IDLE SHALL be ignored.
REQ-030 The buffer SHALL never overflow; an r beat while the buffer is full is impossible by construction, because it is empty at every RD_ADDR entry.

Reset
REQ-031 Asynchronous reset SHALL force IDLE, done=1, error=0, all valid/ready outputs 0, and the buffer empty.
REQ-032 Reset mid-burst SHALL abandon the transfer with no further bus activity.
REQ-033 Address, length and data registers need no reset.

Structure
REQ-034 Package dma_pkg SHALL hold the state enum, the NASTI resp codes (OKAY=0, SLVERR=2), the INCR burst code and the default MAX_BURST.
REQ-035 There SHALL be one sub-module, dma_burst_buf: a MAX_BURST-deep DATA_WIDTH synchronous FIFO with push, pop, full and empty outputs.
REQ-036 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-037 Bench SHALL cover: from=0x1000, to=0x2000, length=64 -> one AR with len=7, 8 R beats, one AW with len=7 and data identical, done rises after the B response, error=0.
REQ-038 Bench SHALL cover: length=160 -> bursts of 8, 8, 4 beats with addresses 0x1000/0x1040/0x1080; w_last only on the final beat of each burst.
REQ-039 Bench SHALL cover: from=0x1FF0, length=64 -> first burst 2 beats (4KB split), then a 6-beat burst at 0x2000.
REQ-040 Bench SHALL cover: length=0 -> done low for 1 cycle, no ar_valid or aw_valid.
REQ-041 Bench SHALL cover: r_resp=SLVERR on beat 3 -> remaining beats drained, no AW, IDLE with error=1; next en clears error.
REQ-042 Bench SHALL cover: random ar_ready/r_valid/aw_ready/w_ready stalls plus aresetn pulsed mid-WR_DATA -> payload stable under stall; after reset done=1 and all valids 0.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and NASTI constants for the DMA mover
package dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam int DEFAULT_MAX_BURST   = 8;

endpackage

// File: rtl/dma_burst_buf.sv
// dma_burst_buf: small synchronous FIFO holding one read burst until it is written out
module dma_burst_buf
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = DEFAULT_MAX_BURST
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  clr_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;
   logic                  do_push, do_pop;

   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q];

   // Pointers and fill level; clr_i empties the buffer between transfers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
         if (do_pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array, no reset needed since occupancy is tracked separately
   always_ff @(posedge aclk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/dma_mover.sv
// dma_mover: NASTI memory-to-memory copier, alternating one read burst and one write burst
module dma_mover
   import dma_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    en_i,
   input  logic [ADDR_WIDTH-1:0]   from_addr_i,
   input  logic [ADDR_WIDTH-1:0]   to_addr_i,
   input  logic [ADDR_WIDTH-1:0]   length_i,
   output logic                    done_o,
   output logic                    error_o,
   output logic [ADDR_WIDTH-1:0]   ar_addr_o,
   output logic [7:0]              ar_len_o,
   output logic [2:0]              ar_size_o,
   output logic [1:0]              ar_burst_o,
   output logic                    ar_valid_o,
   input  logic                    ar_ready_i,
   input  logic [DATA_WIDTH-1:0]   r_data_i,
   input  logic [1:0]              r_resp_i,
   input  logic                    r_last_i,
   input  logic                    r_valid_i,
   output logic                    r_ready_o,
   output logic [ADDR_WIDTH-1:0]   aw_addr_o,
   output logic [7:0]              aw_len_o,
   output logic [2:0]              aw_size_o,
   output logic [1:0]              aw_burst_o,
   output logic                    aw_valid_o,
   input  logic                    aw_ready_i,
   output logic [DATA_WIDTH-1:0]   w_data_o,
   output logic [DATA_WIDTH/8-1:0] w_strb_o,
   output logic                    w_last_o,
   output logic                    w_valid_o,
   input  logic                    w_ready_i,
   input  logic [1:0]              b_resp_i,
   input  logic                    b_valid_i,
   output logic                    b_ready_o
);
   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int SZ         = $clog2(BYTES);
   localparam int PAGE_BEATS = 4096 / BYTES;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d;
   logic [12:0]           rcnt_q, rcnt_d, wcnt_q, wcnt_d;
   logic                  done_q, done_d, err_q, err_d;
   logic [12:0]           src_room, dst_room, rem_cap, c1, c2, n;
   logic                  buf_push, buf_pop, buf_clr, buf_full, buf_empty;
   logic [DATA_WIDTH-1:0] buf_dout;

   // Burst size: limited by MAX_BURST, both 4KB pages and the remaining beats
   assign src_room = 13'(PAGE_BEATS) - 13'(src_q[11:SZ]);
   assign dst_room = 13'(PAGE_BEATS) - 13'(dst_q[11:SZ]);
   assign rem_cap  = (rem_q > ADDR_WIDTH'(PAGE_BEATS)) ? 13'(PAGE_BEATS) : rem_q[12:0];
   assign c1       = (13'(MAX_BURST) < src_room) ? 13'(MAX_BURST) : src_room;
   assign c2       = (dst_room < c1) ? dst_room : c1;
   assign n        = (rem_cap < c2) ? rem_cap : c2;

   assign ar_addr_o  = src_q;
   assign ar_len_o   = 8'(n - 13'd1);
   assign ar_size_o  = 3'(SZ);
   assign ar_burst_o = BURST_INCR;
   assign aw_addr_o  = dst_q;
   assign aw_len_o   = 8'(n - 13'd1);
   assign aw_size_o  = 3'(SZ);
   assign aw_burst_o = BURST_INCR;
   assign w_data_o   = buf_dout;
   assign w_strb_o   = '1;
   assign w_last_o   = wcnt_q == n - 13'd1;
   assign done_o     = done_q;
   assign error_o    = err_q;

   dma_burst_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_BURST)) u_buf (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clr_i   (buf_clr),
      .push_i  (buf_push),
      .din_i   (r_data_i),
      .pop_i   (buf_pop),
      .dout_o  (buf_dout),
      .full_o  (buf_full),
      .empty_o (buf_empty)
   );

   // Next-state and handshake outputs; read and write phases are strictly sequential
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      rem_d      = rem_q;
      rcnt_d     = rcnt_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      ar_valid_o = 1'b0;
      r_ready_o  = 1'b0;
      aw_valid_o = 1'b0;
      w_valid_o  = 1'b0;
      b_ready_o  = 1'b0;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      buf_clr    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            buf_clr = 1'b1;
            if (en_i) begin
               src_d   = from_addr_i & ~ADDR_WIDTH'(BYTES - 1);
               dst_d   = to_addr_i & ~ADDR_WIDTH'(BYTES - 1);
               rem_d   = length_i >> SZ;
               err_d   = 1'b0;
               state_d = (rem_d == '0) ? S_IDLE : S_RD_ADDR;
            end
         end
         S_RD_ADDR: begin
            ar_valid_o = 1'b1;
            rcnt_d     = '0;
            wcnt_d     = '0;
            if (ar_ready_i) state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            r_ready_o = 1'b1;
            if (r_valid_i) begin
               buf_push = !buf_full;
               rcnt_d   = rcnt_q + 13'd1;
               if (r_resp_i != RESP_OKAY) err_d = 1'b1;
               if (r_last_i || rcnt_q == n - 13'd1) state_d = err_d ? S_IDLE : S_WR_ADDR;
            end
         end
         S_WR_ADDR: begin
            aw_valid_o = 1'b1;
            if (aw_ready_i) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            w_valid_o = !buf_empty;
            if (w_valid_o && w_ready_i) begin
               buf_pop = 1'b1;
               wcnt_d  = wcnt_q + 13'd1;
               if (w_last_o) state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            b_ready_o = 1'b1;
            if (b_valid_i) begin
               src_d = src_q + (ADDR_WIDTH'(n) << SZ);
               dst_d = dst_q + (ADDR_WIDTH'(n) << SZ);
               rem_d = rem_q - ADDR_WIDTH'(n);
               if (b_resp_i != RESP_OKAY) err_d = 1'b1;
               state_d = (err_d || rem_d == '0) ? S_IDLE : S_RD_ADDR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_IDLE) && !(state_q == S_IDLE && en_i);
   end

   // Control state; reset abandons any burst in flight
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         rcnt_q  <= '0;
         wcnt_q  <= '0;
         done_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         wcnt_q  <= wcnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Transfer addresses and remaining beat count
   always_ff @(posedge aclk) begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
   end

endmodule
